// File: rtl/dut_ser_arb_if.sv
// Requester-side bundle of dut_ser_arb: request/word inputs plus grant and serial frame outputs.
// The arbiter takes the slave view; the requesters (or a bench) take the master view.
interface dut_ser_arb_if #(
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 8
);
    logic [REQ_NUM-1:0]        I_req;
    logic [REQ_NUM*DATA_W-1:0] I_data;
    logic [REQ_NUM-1:0]        O_gnt;
    logic                      O_ser;
    logic                      O_busy;
    logic [2:0]                O_cur_id;

    modport master (output I_req, I_data, input O_gnt, O_ser, O_busy, O_cur_id);
    modport slave  (input I_req, I_data, output O_gnt, O_ser, O_busy, O_cur_id);
endinterface

// File: rtl/dut_ser_arb.sv
// Round-robin arbiter that serialises the granted word as start/LSB-first data/stop frames.
// Optional even-parity bit between data and stop when DUT_SER_ARB_PARITY_EN is defined.
module dut_ser_arb #(
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 8,
    parameter int BIT_CYC = 4
) (
    input  logic         I_clk,
    input  logic         I_rst,
    dut_ser_arb_if.slave bus
);
    localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef DUT_SER_ARB_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t             state;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [2:0]         ptr;
    logic [2:0]         cur_id;
    logic               ser;
    logic               busy;
    logic [DATA_W-1:0]  shreg;
`ifdef DUT_SER_ARB_PARITY_EN
    logic               parity;
`endif

    logic               bit_end;
    logic               arb_en;
    logic               found;
    logic               take;
    logic [2:0]         win_id;
    logic [2:0]         ptr_next;
    logic [DATA_W-1:0]  win_data;
    logic [REQ_NUM-1:0] gnt;
    int                 idx;

    assign bit_end = (cyc_cnt == CYC_LAST);
    // Grants are blocked during reset so O_gnt stays low while I_rst is asserted.
    assign arb_en  = I_rst && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign take    = arb_en && found;
    assign ptr_next = (win_id == 3'(REQ_NUM - 1)) ? 3'd0 : win_id + 3'd1;

    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        idx      = 0;
        win_data = '0;
        gnt      = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = int'(ptr) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (!found && (i == idx) && bus.I_req[i]) begin
                    found  = 1'b1;
                    win_id = 3'(i);
                end
            end
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (win_id == 3'(i)) win_data = bus.I_data[i*DATA_W +: DATA_W];
            if (take && (win_id == 3'(i))) gnt[i] = 1'b1;
        end
    end

    assign bus.O_gnt    = gnt;
    assign bus.O_ser    = ser;
    assign bus.O_busy   = busy;
    assign bus.O_cur_id = cur_id;

    // Word is captured at grant and shifted so bit 0 always holds the next bit to send.
    always_ff @(posedge I_clk) begin
        if (take) begin
            shreg <= win_data;
`ifdef DUT_SER_ARB_PARITY_EN
            parity <= ^win_data;
`endif
        end else if (bit_end && ((state == ST_START) ||
                                 ((state == ST_DATA) && (bit_cnt != BIT_LAST)))) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            ptr     <= '0;
            cur_id  <= '0;
            ser     <= 1'b1;
            busy    <= 1'b0;
        end else if (take) begin
            state   <= ST_START;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            ptr     <= ptr_next;
            cur_id  <= win_id;
            ser     <= 1'b0;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    ser  <= 1'b1;
                    busy <= 1'b0;
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        cyc_cnt <= '0;
                        ser     <= shreg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef DUT_SER_ARB_PARITY_EN
                            state <= ST_PAR;
                            ser   <= parity;
`else
                            state <= ST_STOP;
                            ser   <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            ser     <= shreg[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`ifdef DUT_SER_ARB_PARITY_EN
                ST_PAR: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        cyc_cnt <= '0;
                        ser     <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state   <= ST_IDLE;
                        cyc_cnt <= '0;
                        ser     <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ser   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dut_ser_arb.sv
// Scoreboard bench for dut_ser_arb: stimulus pushes expected (id, word) pairs, a monitor
// captures each granted frame on O_ser and compares it against the expected waveform.
module tb_dut_ser_arb;
    localparam int REQ_NUM = 4;
    localparam int DATA_W  = 8;
    localparam int BIT_CYC = 4;
`ifdef DUT_SER_ARB_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FLEN = (DATA_W + 2 + PAR_BITS) * BIT_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dut_ser_arb_if #(.REQ_NUM(REQ_NUM), .DATA_W(DATA_W)) bus ();

    dut_ser_arb #(.REQ_NUM(REQ_NUM), .DATA_W(DATA_W), .BIT_CYC(BIT_CYC)) dut (
        .I_clk (clk),
        .I_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected O_ser level for every cycle of a frame carrying word d.
    function automatic logic [63:0] frame_wave(input logic [DATA_W-1:0] d);
        logic [63:0] w;
        int          b;
        w = '0;
        for (int t = 0; t < FLEN; t++) begin
            b = t / BIT_CYC;
            if (b == 0)                                   w[t] = 1'b0;
            else if (b <= DATA_W)                         w[t] = d[b-1];
            else if (PAR_BITS == 1 && b == DATA_W + 1)    w[t] = ^d;
            else                                          w[t] = 1'b1;
        end
        return w;
    endfunction

    task automatic push_exp(input int id, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id   = 3'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic        collecting = 1'b0;
    logic        idle_chk   = 1'b0;
    logic        busy_ok    = 1'b1;
    int          cap_idx    = 0;
    logic [63:0] cap        = '0;
    logic [2:0]  cap_id     = '0;
    logic [2:0]  cap_cur    = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            collecting = 1'b0;
            idle_chk   = 1'b0;
        end else begin
            if (idle_chk) begin
                check("busy_after_frame", bus.O_busy, 1'b0);
                idle_chk = 1'b0;
            end
            if (collecting) begin
                cap[cap_idx] = bus.O_ser;
                if (bus.O_busy !== 1'b1) busy_ok = 1'b0;
                if (cap_idx == 0) cap_cur = bus.O_cur_id;
                cap_idx++;
                if (cap_idx == FLEN) begin
                    collecting = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {61'd0, cap_id}, 64'hFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("gnt_id", cap_id, mon_e.id);
                        check("cur_id", cap_cur, mon_e.id);
                        check("frame_bits", cap, frame_wave(mon_e.data));
                        check("busy_in_frame", busy_ok, 1'b1);
                    end
                    if (bus.O_gnt == '0) idle_chk = 1'b1;
                end
            end
            if (bus.O_gnt != '0) begin
                check("gnt_onehot", $onehot(bus.O_gnt), 1'b1);
                for (int i = 0; i < REQ_NUM; i++)
                    if (bus.O_gnt[i]) cap_id = 3'(i);
                collecting = 1'b1;
                cap_idx    = 0;
                cap        = '0;
                busy_ok    = 1'b1;
            end
        end
    end

    // Stimulus helpers; each returns just after a rising edge so inputs change away from it.
    task automatic wait_any_gnt(input int limit);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(negedge clk);
            if (bus.O_gnt != '0) got = 1'b1;
            n++;
        end
        check("gnt_wait", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.O_busy !== 1'b0 && n < limit);
        check("idle_wait", bus.O_busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [DATA_W-1:0] d);
        bus.I_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        int viol;
        bus.I_req  = '0;
        bus.I_data = '0;

        #12;
        check("rst_ser", bus.O_ser, 1'b1);
        check("rst_busy", bus.O_busy, 1'b0);
        check("rst_gnt", bus.O_gnt, '0);
        check("rst_cur_id", bus.O_cur_id, 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.O_ser !== 1'b1 || bus.O_busy !== 1'b0 || bus.O_gnt !== '0) viol++;
        end
        check("idle_quiet", viol, 0);
        @(posedge clk);
        #1;

        // Round robin with all requesters held: 0,1,2,3,0 back-to-back
        set_slice(0, 8'h11); set_slice(1, 8'h22); set_slice(2, 8'h33); set_slice(3, 8'h44);
        push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33);
        push_exp(3, 8'h44); push_exp(0, 8'h11);
        bus.I_req = 4'b1111;
        repeat (5) wait_any_gnt(400);
        bus.I_req = '0;
        wait_idle(400);

        // Single request on requester 1
        set_slice(1, 8'hA5);
        push_exp(1, 8'hA5);
        bus.I_req = 4'b0010;
        wait_any_gnt(100);
        bus.I_req = '0;
        wait_idle(400);

        // Requester 2 alone; its word changes right after the grant
        set_slice(2, 8'h3C);
        push_exp(2, 8'h3C);
        bus.I_req = 4'b0100;
        wait_any_gnt(100);
        bus.I_req = '0;
        set_slice(2, 8'hFF);
        wait_idle(400);

        // Pointer now past 2: 0 wins by wrapping past 3, then 2
        set_slice(0, 8'h55); set_slice(2, 8'hAA);
        push_exp(0, 8'h55); push_exp(2, 8'hAA);
        bus.I_req = 4'b0101;
        repeat (2) wait_any_gnt(400);
        bus.I_req = '0;
        wait_idle(400);

        // Word 0x07 has odd weight, so a parity bit (when built in) is 1
        set_slice(0, 8'h07);
        push_exp(0, 8'h07);
        bus.I_req = 4'b0001;
        wait_any_gnt(100);
        bus.I_req = '0;
        wait_idle(400);

        // Reset in the middle of a frame, between clock edges
        set_slice(3, 8'h5A);
        bus.I_req = 4'b1000;
        wait_any_gnt(100);
        bus.I_req = '0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_ser", bus.O_ser, 1'b0);
        check("pre_rst_busy", bus.O_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ser", bus.O_ser, 1'b1);
        check("async_rst_busy", bus.O_busy, 1'b0);
        check("async_rst_cur_id", bus.O_cur_id, 3'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.O_ser !== 1'b1 || bus.O_busy !== 1'b0) viol++;
        end
        check("post_rst_quiet", viol, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dut_ser_arb.md
Name: dut_ser_arb

Overview:
- Round-robin arbiter and serial sequencer that shares the single-bit serial input of dut_top between REQ_NUM requesters.
- Grants one requester at a time, latches its parallel word, and shifts it onto O_ser (wired to dut_top I_data_in) as a framed serial stream: start bit, data LSB-first, stop bit.
- Sits directly upstream of dut_top, in the same I_clk domain.

Parameters:
REQ_NUM, 4, number of requesters (2..8)
DATA_W, 8, bits per word (1..32)
BIT_CYC, 4, I_clk cycles each serial bit is held (1..65535)

Ports:
I_clk  in  1  system clock
I_rst  in  1  asynchronous reset, active-low
I_req  in  REQ_NUM  request per requester; held high until granted
I_data  in  REQ_NUM*DATA_W  word per requester; slice i = bits [i*DATA_W +: DATA_W]; valid while I_req[i] high
O_gnt  out  REQ_NUM  one-hot, one-cycle pulse; data slice sampled in that cycle
O_ser  out  1  serial stream to dut_top I_data_in; idle level 1
O_busy  out  1  high while a frame is on O_ser (START through STOP)
O_cur_id  out  3  index of the requester currently being sent; holds last value when idle

Behaviour:
- Reset (I_rst=0, async): O_ser=1, O_gnt=0, O_busy=0, O_cur_id=0, state IDLE, RR pointer=0, all counters=0. Reset asserted mid-frame aborts the frame immediately; no partial-frame resume.
- States: IDLE, START, DATA, PAR (only with macro), STOP.
- Arbitration happens in IDLE, or in the last cycle of STOP:
  - Search starts at the RR pointer and proceeds upward, wrapping modulo REQ_NUM.
  - The first i with I_req[i]=1 wins: O_gnt[i]=1 for that cycle, shift register loads slice i, O_cur_id<=i, pointer<=(i+1) mod REQ_NUM, next state START.
  - No request: stay/enter IDLE with O_ser=1.
- Latency: grant cycle N -> O_ser=0 (start bit) from cycle N+1.
- START: O_ser=0 for BIT_CYC cycles -> DATA.
- DATA: DATA_W bits, LSB first, each held BIT_CYC cycles. Bit counter 0..DATA_W-1. After the last bit -> STOP (or PAR).
- STOP: O_ser=1 for BIT_CYC cycles. The last cycle arbitrates:
  - Grant -> START next cycle, back-to-back with no extra idle.
  - No grant -> IDLE.
- Frame length: (DATA_W+2)*BIT_CYC cycles, or +BIT_CYC with parity.
- O_busy=1 in START/DATA/PAR/STOP, 0 in IDLE. O_busy and O_ser are registered outputs.
- Cycle counter counts 0..BIT_CYC-1 and wraps at bit boundaries. BIT_CYC=1 gives one bit per clock.
- Request dropped before grant: ignored, no error. Request held after grant: treated as a new request at the next arbitration.
- Changes to I_data of the granted slice after the grant cycle have no effect on the frame in flight.

Optional Feature:
- Macro DUT_SER_ARB_PARITY_EN.
- Defined: state PAR is inserted between DATA and STOP. O_ser carries even parity (XOR of the DATA_W data bits) for BIT_CYC cycles. Frame length is (DATA_W+3)*BIT_CYC.
- Undefined: PAR state and parity logic are absent; DATA goes straight to STOP.

Test Plan:
- Reset, then I_req=0 for 50 cycles -> O_ser=1, O_busy=0, O_gnt=0 throughout. Assert I_rst=0 mid-frame -> O_ser=1 and O_busy=0 immediately, without waiting for a clock edge.
- Single request: REQ_NUM=4, DATA_W=8, BIT_CYC=4; I_req=4'b0010, slice1=8'hA5. Expect:
  - O_gnt=4'b0010 for one cycle;
  - O_ser=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles;
  - O_busy high for exactly 40 cycles; O_cur_id=1.
- Round-robin: I_req=4'b1111 held continuously with distinct data -> grant order 0,1,2,3,0. Frames are back-to-back: each start bit begins the cycle after the previous stop bit ends, with no idle gap.
- Pointer fairness: after serving 2, I_req=4'b0101 -> next grant is 0 (wrap past 3). Following grant is 2.
- Parity build: with DUT_SER_ARB_PARITY_EN defined, slice0=8'h07 -> parity bit=1 inserted after the data bits, O_busy high for 44 cycles. With the macro undefined, the same stimulus gives no parity bit and 40 cycles.
- Data stability: change the granted slice from 8'h3C to 8'hFF one cycle after O_gnt -> the transmitted bits still encode 8'h3C.
